// File: rtl/imem_pkg.sv
// Shared types and helpers for the boot-clearing instruction memory.
// Holds the NOP encoding, the FSM state type and the fetch/load address checker.
package imem_pkg;

   localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
   localparam int          CHK_ADDR_W = 64;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   typedef struct packed {
      logic misaligned;
      logic out_of_range;
   } addr_chk_t;

   // Addresses are zero-extended to CHK_ADDR_W so one checker serves any ADDR_W.
   function automatic addr_chk_t addr_check(
      input logic [CHK_ADDR_W-1:0] addr,
      input int                    idx_w
   );
      addr_chk_t chk;
      chk.misaligned   = (addr[1:0] != 2'b00);
      chk.out_of_range = ((addr >> (idx_w + 2)) != '0);
      return chk;
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Word-addressed instruction RAM: one synchronous write port, one registered read port.
// The read register holds its value whenever no read is enabled.
module imem_ram #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
   logic [DATA_W-1:0] r_rdata;

   // NOTE: the array has no reset so it maps onto block RAM; the clear walk zeroes it instead.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_boot_ram.sv
// Registered-read instruction memory that zeroes itself after reset, accepts a program
// through a loader port and answers fetches one cycle after a req/ready handshake.
module imem_boot_ram
   import imem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_err,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_instr,
   output logic              fetch_fault,
   output logic              busy
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [IDX_W:0] CLR_LAST = (IDX_W + 1)'(DEPTH_WORDS - 1);

   if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("imem_boot_ram: DEPTH_WORDS must be a power of two and at least 2");
   end
   if (ADDR_W < IDX_W + 2 || ADDR_W > CHK_ADDR_W) begin : g_bad_addr_w
      $error("imem_boot_ram: ADDR_W cannot address DEPTH_WORDS words");
   end

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W:0]    r_clr_cnt;
   logic              w_clr_last;
   logic              w_clr_we;

   addr_chk_t         w_ld_chk;
   addr_chk_t         w_fe_chk;
   logic              w_ld_bad;
   logic              w_fe_bad;
   logic              w_load_wr;
   logic              w_load_rej;
   logic              w_fetch_acc;
   logic              w_fetch_rd;

   logic              w_ram_we;
   logic [IDX_W-1:0]  w_ram_waddr;
   logic [DATA_W-1:0] w_ram_wdata;
   logic [DATA_W-1:0] w_ram_rdata;

   logic              r_fetch_valid;
   logic              r_fetch_fault;
   logic              r_load_err;
   logic              r_sel_nop;

   // ---------------------------------------------------------------- address checks
   assign w_ld_chk = addr_check(CHK_ADDR_W'(load_addr), IDX_W);
   assign w_fe_chk = addr_check(CHK_ADDR_W'(fetch_addr), IDX_W);
   assign w_ld_bad = w_ld_chk.misaligned | w_ld_chk.out_of_range;
   assign w_fe_bad = w_fe_chk.misaligned | w_fe_chk.out_of_range;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_clr_last = (r_clr_cnt == CLR_LAST);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CLEAR:   if (w_clr_last) w_state_nxt = READY;
         READY:   w_state_nxt = READY;
         default: w_state_nxt = CLEAR;
      endcase
   end

   // A pending load owns the write port, so fetch is stalled for that cycle.
   always_comb begin
      busy        = 1'b0;
      fetch_ready = 1'b0;
      w_clr_we    = 1'b0;
      case (r_state)
         CLEAR: begin
            busy     = 1'b1;
            w_clr_we = 1'b1;
         end
         READY:   fetch_ready = !load_en;
         default: ;
      endcase
   end

   // Stops on the top index, so the extra counter bit never gets set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clr_cnt <= '0;
      end else if (r_state == CLEAR && !w_clr_last) begin
         r_clr_cnt <= r_clr_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- loader and handshake
   assign w_load_wr   = (r_state == READY) && load_en && !w_ld_bad;
   assign w_load_rej  = (r_state == READY) && load_en &&  w_ld_bad;
   assign w_fetch_acc = fetch_req && fetch_ready;
   assign w_fetch_rd  = w_fetch_acc && !w_fe_bad;

   assign w_ram_we    = w_clr_we | w_load_wr;
   assign w_ram_waddr = w_clr_we ? r_clr_cnt[IDX_W-1:0] : load_addr[IDX_W+1:2];
   assign w_ram_wdata = w_clr_we ? '0 : load_data;

   imem_ram #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_re    (w_fetch_rd),
      .i_raddr (fetch_addr[IDX_W+1:2]),
      .o_rdata (w_ram_rdata)
   );

   // ---------------------------------------------------------------- output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_valid <= 1'b0;
         r_fetch_fault <= 1'b0;
         r_load_err    <= 1'b0;
         r_sel_nop     <= 1'b0;
      end else begin
         r_fetch_valid <= w_fetch_acc;
         r_fetch_fault <= w_fetch_acc && w_fe_bad;
         r_load_err    <= w_load_rej;
         if (w_fetch_acc) begin
            r_sel_nop <= w_fe_bad;
         end
      end
   end

   // A faulting fetch skips the RAM read; the NOP select masks the stale read register.
   assign fetch_instr = r_sel_nop ? DATA_W'(INSTR_NOP) : w_ram_rdata;
   assign fetch_valid = r_fetch_valid;
   assign fetch_fault = r_fetch_fault;
   assign load_err    = r_load_err;

endmodule

// File: tb/tb_imem_boot_ram.sv
// Self-checking bench for imem_boot_ram (DEPTH_WORDS = 16): directed scenarios plus a
// randomized load/fetch mix checked against an array-based reference model.
module tb_imem_boot_ram;

   localparam int          ADDR_W = 32;
   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 16;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk        = 1'b0;
   logic              rst        = 1'b0;
   logic              load_en    = 1'b0;
   logic [ADDR_W-1:0] load_addr  = '0;
   logic [DATA_W-1:0] load_data  = '0;
   logic              fetch_req  = 1'b0;
   logic [ADDR_W-1:0] fetch_addr = '0;
   logic              load_err;
   logic              fetch_ready;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_instr;
   logic              fetch_fault;
   logic              busy;

   always #5 clk = ~clk;

   imem_boot_ram #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .load_err    (load_err),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .fetch_instr (fetch_instr),
      .fetch_fault (fetch_fault),
      .busy        (busy)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: word array plus the number of clear cycles still to run.
   logic [31:0] m_mem [DEPTH];
   int          m_clear_left;
   logic        exp_valid, exp_fault, exp_lerr, exp_busy_pre, exp_ready_pre;
   logic [31:0] exp_instr;
   logic        act_busy_pre, act_ready_pre;

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a < 4 * DEPTH);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      foreach (m_mem[i]) m_mem[i] = '0;
      m_clear_left = DEPTH;
      exp_valid    = 1'b0;
      exp_fault    = 1'b0;
      exp_lerr     = 1'b0;
      exp_instr    = '0;
   endtask

   // Drives one cycle, samples the combinational outputs mid-cycle, advances the model
   // and leaves the expected registered outputs in exp_*.
   task automatic run_cycle(input logic le, input logic [31:0] la, input logic [31:0] ld,
                            input logic fr, input logic [31:0] fa);
      bit rdy;
      bit acc;
      load_en    = le;
      load_addr  = la;
      load_data  = ld;
      fetch_req  = fr;
      fetch_addr = fa;
      #1;
      act_busy_pre  = busy;
      act_ready_pre = fetch_ready;
      rdy           = (m_clear_left == 0);
      exp_busy_pre  = !rdy;
      exp_ready_pre = rdy && !le;
      acc           = fr && exp_ready_pre;
      exp_valid     = acc;
      exp_fault     = acc && !legal(fa);
      if (acc) exp_instr = legal(fa) ? m_mem[int'(fa / 4)] : NOP;
      exp_lerr      = rdy && le && !legal(la);
      if (rdy && le && legal(la)) m_mem[int'(la / 4)] = ld;
      if (!rdy) m_clear_left--;
      step();
   endtask

   task automatic idle();
      run_cycle(1'b0, '0, '0, 1'b0, '0);
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)       return 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (sel == 7) return 32'($urandom_range(0, 4 * DEPTH - 1));
      else if (sel == 8) return 32'(4 * DEPTH + $urandom_range(0, 191));
      else               return 32'($urandom());
   endfunction

   task automatic test_reset();
      model_reset();
      #2;
      n_cmp++;
      if ({busy, fetch_ready, fetch_valid, fetch_fault, load_err, fetch_instr} !== {5'b10000, 32'h0}) begin
         n_mis++;
         $display("FAIL reset_values: got busy=%b rdy=%b v=%b f=%b le=%b i=%h want 1 0 0 0 0 00000000",
                  busy, fetch_ready, fetch_valid, fetch_fault, load_err, fetch_instr);
      end
      load_en   = 1'b1;
      load_addr = 32'h41;
      fetch_req = 1'b1;
      repeat (3) step();
      n_cmp++;
      if ({busy, fetch_ready, fetch_valid, load_err} !== 4'b1000) begin
         n_mis++;
         $display("FAIL reset_held: got busy=%b rdy=%b v=%b le=%b want 1 0 0 0",
                  busy, fetch_ready, fetch_valid, load_err);
      end
      load_en   = 1'b0;
      load_addr = '0;
      fetch_req = 1'b0;
   endtask

   task automatic test_clear();
      rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         run_cycle(1'b0, '0, '0, 1'b1, 32'h0);
         n_cmp++;
         if ({act_busy_pre, act_ready_pre, fetch_valid} !== 3'b100) begin
            n_mis++;
            $display("FAIL clear_cycle[%0d]: got busy=%b rdy=%b v=%b want 1 0 0",
                     i, act_busy_pre, act_ready_pre, fetch_valid);
         end
      end
      run_cycle(1'b0, '0, '0, 1'b1, 32'h0);
      n_cmp++;
      if ({act_busy_pre, act_ready_pre} !== 2'b01) begin
         n_mis++;
         $display("FAIL clear_ready_rise: got busy=%b rdy=%b want 0 1", act_busy_pre, act_ready_pre);
      end
      n_cmp++;
      if ({fetch_valid, fetch_fault, fetch_instr} !== {2'b10, 32'h0}) begin
         n_mis++;
         $display("FAIL clear_first_fetch: got v=%b f=%b i=%h want 1 0 00000000",
                  fetch_valid, fetch_fault, fetch_instr);
      end
      idle();
   endtask

   task automatic test_load_fetch();
      run_cycle(1'b1, 32'h0, 32'h0062_E233, 1'b0, '0);
      run_cycle(1'b1, 32'h4, 32'h0083_2383, 1'b0, '0);
      run_cycle(1'b0, '0, '0, 1'b1, 32'h0);
      n_cmp++;
      if ({fetch_valid, fetch_fault, fetch_instr} !== {2'b10, 32'h0062_E233}) begin
         n_mis++;
         $display("FAIL load_fetch_0: got v=%b f=%b i=%h want 1 0 0062e233", fetch_valid, fetch_fault, fetch_instr);
      end
      run_cycle(1'b0, '0, '0, 1'b1, 32'h4);
      n_cmp++;
      if ({fetch_valid, fetch_fault, fetch_instr} !== {2'b10, 32'h0083_2383}) begin
         n_mis++;
         $display("FAIL load_fetch_4: got v=%b f=%b i=%h want 1 0 00832383", fetch_valid, fetch_fault, fetch_instr);
      end
      idle();
      n_cmp++;
      if ({fetch_valid, fetch_fault, fetch_instr} !== {2'b00, 32'h0083_2383}) begin
         n_mis++;
         $display("FAIL load_fetch_hold: got v=%b f=%b i=%h want 0 0 00832383", fetch_valid, fetch_fault, fetch_instr);
      end
   endtask

   task automatic test_faults();
      run_cycle(1'b0, '0, '0, 1'b1, 32'h2);
      n_cmp++;
      if ({fetch_valid, fetch_fault, fetch_instr} !== {2'b11, NOP}) begin
         n_mis++;
         $display("FAIL fault_misaligned: got v=%b f=%b i=%h want 1 1 %h", fetch_valid, fetch_fault, fetch_instr, NOP);
      end
      run_cycle(1'b0, '0, '0, 1'b1, 32'h40);
      n_cmp++;
      if ({fetch_valid, fetch_fault, fetch_instr} !== {2'b11, NOP}) begin
         n_mis++;
         $display("FAIL fault_range: got v=%b f=%b i=%h want 1 1 %h", fetch_valid, fetch_fault, fetch_instr, NOP);
      end
      idle();
      n_cmp++;
      if ({fetch_valid, fetch_fault} !== 2'b00) begin
         n_mis++;
         $display("FAIL fault_idle: got v=%b f=%b want 0 0", fetch_valid, fetch_fault);
      end
      run_cycle(1'b0, '0, '0, 1'b1, 32'h0);
      n_cmp++;
      if ({fetch_valid, fetch_fault, fetch_instr} !== {2'b10, 32'h0062_E233}) begin
         n_mis++;
         $display("FAIL fault_mem_intact: got v=%b f=%b i=%h want 1 0 0062e233", fetch_valid, fetch_fault, fetch_instr);
      end
   endtask

   task automatic test_collision();
      run_cycle(1'b1, 32'h8, 32'hFFC4_A303, 1'b1, 32'h8);
      n_cmp++;
      if ({act_ready_pre, fetch_valid, load_err} !== 3'b000) begin
         n_mis++;
         $display("FAIL collision_stall: got rdy=%b v=%b le=%b want 0 0 0", act_ready_pre, fetch_valid, load_err);
      end
      run_cycle(1'b0, '0, '0, 1'b1, 32'h8);
      n_cmp++;
      if ({act_ready_pre, fetch_valid, fetch_fault, fetch_instr} !== {3'b110, 32'hFFC4_A303}) begin
         n_mis++;
         $display("FAIL collision_fetch: got rdy=%b v=%b f=%b i=%h want 1 1 0 ffc4a303",
                  act_ready_pre, fetch_valid, fetch_fault, fetch_instr);
      end
      idle();
   endtask

   task automatic test_random();
      logic        fr      = 1'b0;
      logic [31:0] fa      = '0;
      bit          pending = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic        le;
         logic [31:0] la;
         logic [31:0] ld;
         le = ($urandom_range(0, 3) == 0);
         la = rand_addr();
         ld = $urandom();
         if (!pending) begin
            fr = ($urandom_range(0, 9) < 7);
            fa = rand_addr();
         end
         run_cycle(le, la, ld, fr, fa);
         pending = fr && !exp_valid;
         n_cmp++;
         if ({act_busy_pre, act_ready_pre} !== {exp_busy_pre, exp_ready_pre}) begin
            n_mis++;
            $display("FAIL rand_comb[%0d]: got busy=%b rdy=%b want %b %b",
                     i, act_busy_pre, act_ready_pre, exp_busy_pre, exp_ready_pre);
         end
         n_cmp++;
         if ({fetch_valid, fetch_fault, load_err, fetch_instr} !== {exp_valid, exp_fault, exp_lerr, exp_instr}) begin
            n_mis++;
            $display("FAIL rand_out[%0d]: got v=%b f=%b le=%b i=%h want %b %b %b %h", i,
                     fetch_valid, fetch_fault, load_err, fetch_instr, exp_valid, exp_fault, exp_lerr, exp_instr);
         end
      end
      idle();
   endtask

   task automatic test_illegal_load();
      rst = 1'b0;
      model_reset();
      step();
      rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         run_cycle(1'b1, 32'h41, 32'hDEAD_BEEF, 1'b0, '0);
         n_cmp++;
         if ({act_busy_pre, load_err} !== 2'b10) begin
            n_mis++;
            $display("FAIL clear_load_ignored[%0d]: got busy=%b le=%b want 1 0", i, act_busy_pre, load_err);
         end
      end
      run_cycle(1'b1, 32'h0, 32'h1234_5678, 1'b0, '0);
      run_cycle(1'b1, 32'h41, 32'hDEAD_BEEF, 1'b0, '0);
      n_cmp++;
      if (load_err !== 1'b1) begin
         n_mis++;
         $display("FAIL illegal_load_pulse: got le=%b want 1", load_err);
      end
      idle();
      n_cmp++;
      if (load_err !== 1'b0) begin
         n_mis++;
         $display("FAIL illegal_load_width: got le=%b want 0", load_err);
      end
      for (int i = 0; i < DEPTH; i++) begin
         run_cycle(1'b0, '0, '0, 1'b1, 32'(4 * i));
         n_cmp++;
         if ({fetch_valid, fetch_instr} !== {1'b1, (i == 0) ? 32'h1234_5678 : 32'h0}) begin
            n_mis++;
            $display("FAIL illegal_load_mem[%0d]: got v=%b i=%h want 1 %h",
                     i, fetch_valid, fetch_instr, (i == 0) ? 32'h1234_5678 : 32'h0);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      run_cycle(1'b1, 32'hC, 32'hA5A5_0F0F, 1'b0, '0);
      run_cycle(1'b0, '0, '0, 1'b1, 32'hC);
      n_cmp++;
      if ({fetch_valid, fetch_instr} !== {1'b1, 32'hA5A5_0F0F}) begin
         n_mis++;
         $display("FAIL mid_pre_fetch: got v=%b i=%h want 1 a5a50f0f", fetch_valid, fetch_instr);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({busy, fetch_ready, fetch_valid, fetch_fault, load_err, fetch_instr} !== {5'b10000, 32'h0}) begin
         n_mis++;
         $display("FAIL mid_reset_async: got busy=%b rdy=%b v=%b f=%b le=%b i=%h want 1 0 0 0 0 00000000",
                  busy, fetch_ready, fetch_valid, fetch_fault, load_err, fetch_instr);
      end
      model_reset();
      step();
      rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         run_cycle(1'b0, '0, '0, 1'b1, 32'hC);
         n_cmp++;
         if ({act_busy_pre, act_ready_pre, fetch_valid} !== 3'b100) begin
            n_mis++;
            $display("FAIL mid_reclear[%0d]: got busy=%b rdy=%b v=%b want 1 0 0",
                     i, act_busy_pre, act_ready_pre, fetch_valid);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         run_cycle(1'b0, '0, '0, 1'b1, 32'(4 * ((i + 3) % DEPTH)));
         n_cmp++;
         if ({act_ready_pre, fetch_valid, fetch_fault, fetch_instr} !== {3'b110, 32'h0}) begin
            n_mis++;
            $display("FAIL mid_cleared[%0d]: got rdy=%b v=%b f=%b i=%h want 1 1 0 00000000",
                     i, act_ready_pre, fetch_valid, fetch_fault, fetch_instr);
         end
      end
      idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_clear();
      test_load_fetch();
      test_faults();
      test_collision();
      test_random();
      test_illegal_load();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/imem_boot_ram.md
# imem_boot_ram

Parametrised instruction memory for the single-cycle RISC-V core. It replaces the combinational, simulation-preloaded instruction store with a registered-read RAM that clears itself after reset, accepts a program through a loader port, and returns fetched instructions one cycle after a handshake. Misaligned and out-of-range fetch addresses are flagged as faults.

## Interface
- `ADDR_W`, default 32: byte-address width of fetch and load addresses.
- `DATA_W`, default 32: instruction width.
- `DEPTH_WORDS`, default 1024: number of words; must be a power of two, at least 2.
- `clk` input 1: clock; all state changes on rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `load_en` input 1: loader write strobe.
- `load_addr` input ADDR_W: loader byte address.
- `load_data` input DATA_W: word to write.
- `load_err` output 1: one-cycle pulse when a load is rejected as illegal.
- `fetch_req` input 1: fetch request.
- `fetch_addr` input ADDR_W: fetch byte address, normally the PC.
- `fetch_ready` output 1: a request is accepted this cycle.
- `fetch_valid` output 1: `fetch_instr` is valid this cycle.
- `fetch_instr` output DATA_W: fetched word, or NOP on fault.
- `fetch_fault` output 1: qualifies `fetch_valid`; the access was misaligned or out of range.
- `busy` output 1: high while the post-reset clear is running.

## Operation
- Word index = `addr[IDX_W+1:2]`, where IDX_W = log2(DEPTH_WORDS).
- An address is misaligned when `addr[1:0] != 0`.
- An address is out of range when any bit above IDX_W+1 is nonzero.
- FSM states:
  - CLEAR: entered on reset. A counter walks index 0 to DEPTH_WORDS-1, writing 0 to one word per cycle. After the last index it goes to READY.
  - READY: normal operation. The FSM has no other states.
- `busy` is 1 in CLEAR. `fetch_ready` is 0 in CLEAR.
- In CLEAR, `load_en` is ignored and does not pulse `load_err`.
- Load in READY:
  - A legal `load_en` writes `load_data` at the end of the cycle.
  - An illegal load (misaligned or out of range) writes nothing. `load_err` = 1 on the next cycle.
- Fetch handshake:
  - A transfer occurs when `fetch_req && fetch_ready`.
  - `fetch_ready` = (state == READY) && !`load_en`. Load has priority and stalls fetch.
  - `fetch_req` may be held. The requester keeps `fetch_addr` stable until accepted.
- Accepted legal fetch: the next cycle gives `fetch_valid` = 1, `fetch_fault` = 0, and `fetch_instr` = mem[index].
- Accepted illegal fetch: the next cycle gives `fetch_valid` = 1, `fetch_fault` = 1, and `fetch_instr` = NOP (32'h00000013). No RAM read is performed.
- No accepted fetch: the next cycle gives `fetch_valid` = 0 and `fetch_fault` = 0. `fetch_instr` holds its last value.
- Read-after-write: a load in cycle N followed by a fetch of the same word in cycle N+1 returns the new data. There is no bypass path, because the write completes before the read.

## Timing
- Reset values (asynchronous, while `rst` = 0):
  - state = CLEAR, counter = 0.
  - `busy` = 1, `fetch_ready` = 0.
  - `fetch_valid` = 0, `fetch_fault` = 0, `load_err` = 0.
  - `fetch_instr` = 0.
- Clear duration: exactly DEPTH_WORDS cycles after `rst` deasserts. `fetch_ready` first rises on cycle DEPTH_WORDS.
- Fetch latency: 1 cycle, accept to valid. Throughput is one fetch per cycle when no load is present.
- `load_err` latency: 1 cycle.
- Reset asserted mid-clear, mid-load or mid-fetch:
  - All outputs return to their reset values immediately.
  - A pending `fetch_valid` is dropped.
  - The clear restarts from index 0.
- Counter wrap: the counter is IDX_W+1 bits wide. The transition to READY happens on the cycle that writes the top index, so the counter never wraps.

## Structure
- Package `imem_pkg`:
  - `INSTR_NOP` = 32'h00000013.
  - State enum {CLEAR, READY}.
  - Address-check function returning {misaligned, out_of_range}.
- Sub-module `imem_ram`:
  - One synchronous write port and one registered read port.
  - DEPTH_WORDS x DATA_W, with no reset on the array.
  - The write port is muxed between the clear counter and the loader.
- Top level holds the FSM, the clear counter, address checks, the handshake and the output registers.

## Test plan
All scenarios use a bench with DEPTH_WORDS = 16.
- Clear after reset:
  - Stimulus: release `rst`, hold `fetch_req` = 1 at `fetch_addr` = 0x0.
  - Required: `busy` stays 1 for 16 cycles. `fetch_ready` rises on cycle 16. The next cycle gives `fetch_valid` = 1 and `fetch_instr` = 0x00000000.
- Load then fetch:
  - Stimulus: load 0x0062E233 at 0x0 and 0x00832383 at 0x4, then fetch 0x0 and 0x4 back-to-back.
  - Required: valid on consecutive cycles with 0x0062E233 and then 0x00832383.
- Fetch faults:
  - Fetch 0x2. Required: `fetch_fault` = 1 and `fetch_instr` = 0x00000013.
  - Fetch 0x40. Required: `fetch_fault` = 1. Memory content is unchanged.
- Load/fetch collision:
  - Stimulus: `load_en` and `fetch_req` in the same cycle, both at 0x8, with `load_data` = 0xFFC4A303.
  - Required: `fetch_ready` = 0 in that cycle. The fetch is accepted the next cycle and returns 0xFFC4A303.
- Illegal load:
  - Stimulus: load at 0x41.
  - Required: `load_err` pulses for 1 cycle and no word changes. The same load during CLEAR produces no pulse.
- Reset mid-operation:
  - Stimulus: assert `rst` one cycle after a fetch is accepted.
  - Required: `fetch_valid` goes to 0 immediately. The clear reruns for 16 cycles. The earlier contents read back as 0.
